// File: rtl/wallace_mac_pkg.sv
// Shared types and sizing for the Wallace-tree MAC sequencer.
// Holds the FSM encoding, multiplier width and accumulator sizing helper.
package wallace_mac_pkg;

    localparam int MUL_W       = 16;
    localparam int DEF_N_TERMS = 8;
    localparam int DEF_ACC_W   = 19;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        OUT
    } state_t;

    function automatic int acc_min_w(input int n);
        return MUL_W + $clog2(n);
    endfunction

endpackage

// File: rtl/wallace_mac_sequencer_mul.sv
// eight_bit_wallace_tree: approximate 8x8 unsigned multiplier.
// Columns 0..3 are OR-compressed without carries; the rest go through a CSA tree.
module eight_bit_wallace_tree
    import wallace_mac_pkg::*;
(
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    output logic [MUL_W-1:0] p
);

    localparam logic [MUL_W-1:0] HI_MASK = 16'hFFF0;

    logic [MUL_W-1:0] row [8];
    logic [MUL_W-1:0] lo;
    logic [MUL_W-1:0] s0, c0, s1, c1, s2, c2;
    logic [MUL_W-1:0] s3, c3, s4, c4, s5, c5;

    function automatic logic [2*MUL_W-1:0] csa(
        input logic [MUL_W-1:0] x,
        input logic [MUL_W-1:0] y,
        input logic [MUL_W-1:0] z
    );
        logic [MUL_W-1:0] s;
        logic [MUL_W-1:0] c;
        s = x ^ y ^ z;
        c = ((x & y) | (x & z) | (y & z)) << 1;
        return {c, s};
    endfunction

    always_comb begin
        lo = '0;
        for (int i = 0; i < 8; i++) begin
            row[i] = ({8'h00, a & {8{b[i]}}} << i);
            lo     = lo | (row[i] & ~HI_MASK);
            row[i] = row[i] & HI_MASK;
        end
    end

    // 8 rows -> 6 -> 4 -> 3 -> 2, then one carry-propagate add
    assign {c0, s0} = csa(row[0], row[1], row[2]);
    assign {c1, s1} = csa(row[3], row[4], row[5]);
    assign {c2, s2} = csa(s0, c0, s1);
    assign {c3, s3} = csa(c1, row[6], row[7]);
    assign {c4, s4} = csa(s2, c2, s3);
    assign {c5, s5} = csa(s4, c4, c3);

    assign p = (s5 + c5) | lo;

endmodule

// File: rtl/wallace_mac_sequencer.sv
// Streams operand pairs through the approximate multiplier and
// accumulates N_TERMS products into one result per group.
module wallace_mac_sequencer
    import wallace_mac_pkg::*;
#(
    parameter int N_TERMS = DEF_N_TERMS,
    parameter int ACC_W   = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             busy
);

    localparam int CNT_W = $clog2(N_TERMS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    if (N_TERMS < 2) begin : g_bad_terms
        $error("N_TERMS must be at least 2");
    end
    if (ACC_W < acc_min_w(N_TERMS)) begin : g_bad_acc_w
        $error("ACC_W too narrow for N_TERMS products");
    end

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             prod_v;
    logic [MUL_W-1:0] prod_r;
    logic [ACC_W-1:0] acc;
    logic [MUL_W-1:0] mul_p;
    logic             accept;
    logic             last;

    eight_bit_wallace_tree u_mul (
        .a (a),
        .b (b),
        .p (mul_p)
    );

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == OUT);
    assign acc_out   = acc;
    assign busy      = (state == ACCUM && cnt != '0)
                     || state == DRAIN || state == OUT;

    assign accept = in_valid & in_ready;
    assign last   = accept && (cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            prod_v <= 1'b0;
            prod_r <= '0;
            acc    <= '0;
        end else if (clear && state != IDLE) begin
            // abort wins over any same-cycle accept or result handshake
            state  <= ACCUM;
            cnt    <= '0;
            prod_v <= 1'b0;
            acc    <= '0;
        end else begin
            prod_v <= accept;
            if (accept) begin
                prod_r <= mul_p;
                cnt    <= last ? '0 : cnt + 1'b1;
            end

            if (state == OUT && out_ready) begin
                acc <= '0;
            end else if (prod_v) begin
                acc <= acc + ACC_W'(prod_r);
            end

            unique case (state)
                IDLE:    state <= ACCUM;
                ACCUM:   if (last) state <= DRAIN;
                DRAIN:   state <= OUT;
                OUT:     if (out_ready) state <= ACCUM;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wallace_mac_sequencer.sv
// Directed bench for wallace_mac_sequencer.
// Expected sums come from hand constants and a bit-level multiplier model.
module tb_wallace_mac_sequencer;
    import wallace_mac_pkg::*;

    localparam int ACC_W = 19;

    typedef logic [7:0] vec8_t [8];

    logic             clk;
    logic             rst_n;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       a;
    logic [7:0]       b;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic             busy;

    int n_vec;
    int n_bad;

    wallace_mac_sequencer #(
        .N_TERMS (8),
        .ACC_W   (ACC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Columns 0..3 OR-ed, higher columns summed exactly
    function automatic int mul_ref(input logic [7:0] x,
                                   input logic [7:0] y);
        int hi;
        int lo;
        hi = 0;
        lo = 0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                if (x[j] && y[i]) begin
                    if (i + j < 4) lo = lo | (1 << (i + j));
                    else           hi = hi + (1 << (i + j));
                end
        return hi + lo;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_group(input vec8_t av, input vec8_t bv,
                             input bit bubble, output int edges);
        int  k;
        bit  took;
        k     = 0;
        edges = 0;
        while (k < 8 && edges < 200) begin
            in_valid = bubble ? 1'($urandom_range(0, 1)) : 1'b1;
            a        = av[k];
            b        = bv[k];
            took     = in_valid && in_ready;
            step();
            edges++;
            if (took) k++;
        end
        in_valid = 1'b0;
        check("accepts", k, 8);
        check("in_ready_after_last", in_ready, 0);
        while (!out_valid && edges < 200) begin
            step();
            edges++;
        end
        check("out_valid_seen", out_valid, 1);
    endtask

    task automatic finish_out();
        out_ready = 1'b1;
        step();
        check("out_released", out_valid, 0);
        check("next_in_ready", in_ready, 1);
    endtask

    vec8_t ff_v, zero_v, idx_v, one_v, nib_v, ma_v, mb_v;
    int    edges;
    int    exp_mix;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_bad = 0;
        ma_v  = '{8'd3, 8'd200, 8'd17, 8'd255,
                  8'd128, 8'd99, 8'd64, 8'd7};
        mb_v  = '{8'd5, 8'd3, 8'd250, 8'd1,
                  8'd128, 8'd77, 8'd2, 8'd255};
        for (int i = 0; i < 8; i++) begin
            ff_v[i]   = 8'hFF;
            zero_v[i] = 8'h00;
            idx_v[i]  = 8'(i);
            one_v[i]  = 8'h01;
            nib_v[i]  = 8'h0F;
        end
        idx_v[0] = 8'd0;
        exp_mix  = 0;
        for (int i = 0; i < 8; i++)
            exp_mix += mul_ref(ma_v[i], mb_v[i]);

        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = 8'h00;
        b         = 8'h00;

        repeat (3) step();
        check("rst_out_valid", out_valid, 0);
        check("rst_acc_out", acc_out, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        step();
        check("post_rst_in_ready", in_ready, 1);

        // back-to-back full-scale operands
        check("model_ff", mul_ref(8'hFF, 8'hFF), 64991);
        run_group(ff_v, ff_v, 1'b0, edges);
        check("out_cycle", edges + 1, 10);
        check("sum_ff", acc_out, 519928);
        check("busy_out", busy, 1);
        finish_out();

        run_group(idx_v, zero_v, 1'b0, edges);
        check("sum_zero_a", acc_out, 0);
        finish_out();
        for (int i = 0; i < 8; i++) idx_v[i] = 8'(i + 1);
        run_group(one_v, idx_v, 1'b0, edges);
        check("sum_identity", acc_out, 36);
        finish_out();
        run_group(nib_v, nib_v, 1'b0, edges);
        check("sum_nibble", acc_out, 1528);
        finish_out();

        // result held under backpressure
        out_ready = 1'b0;
        run_group(ff_v, ff_v, 1'b0, edges);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_acc_hold", acc_out, 519928);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
        end
        finish_out();

        // random input bubbles
        for (int g = 0; g < 2; g++) begin
            run_group(ff_v, ff_v, 1'b1, edges);
            check("sum_bubble", acc_out, 519928);
            finish_out();
        end

        // clear mid-group drops the same-cycle term
        in_valid = 1'b1;
        a        = 8'hFF;
        b        = 8'hFF;
        repeat (5) step();
        check("pre_clear_busy", busy, 1);
        clear = 1'b1;
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clr_acc", acc_out, 0);
        check("clr_busy", busy, 0);
        check("clr_in_ready", in_ready, 1);
        step();
        check("clr_acc_settled", acc_out, 0);
        run_group(one_v, idx_v, 1'b0, edges);
        check("sum_after_clear", acc_out, 36);
        finish_out();

        // clear while a result waits in OUT
        out_ready = 1'b0;
        run_group(ff_v, ff_v, 1'b0, edges);
        check("sum_before_clear", acc_out, 519928);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_out_valid", out_valid, 0);
        check("clr_out_acc", acc_out, 0);
        out_ready = 1'b1;
        run_group(nib_v, nib_v, 1'b0, edges);
        check("sum_after_out_clear", acc_out, 1528);
        finish_out();

        // reset in the middle of a group
        in_valid = 1'b1;
        repeat (3) step();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        step();
        check("midrst_in_ready", in_ready, 0);
        check("midrst_acc", acc_out, 0);
        check("midrst_busy", busy, 0);
        rst_n = 1'b1;
        step();
        check("midrst_release", in_ready, 1);
        run_group(ma_v, mb_v, 1'b0, edges);
        check("sum_mixed", acc_out, 32'(exp_mix));
        finish_out();

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
